prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Hardware program loader. It is the writer side of the memory/register image that the CPU bench reads back after a syscall.
- Accepts a 32-bit word stream (valid/ready), writes the text segment into instruction memory and the data segment into data memory.
- Initialises $gp and $sp to MARS values, then releases the CPU from reset.
- Afterwards it watches the CPU syscall line and reports a halt.

Parameters:
- TEXT_WORDS, 1024, instruction memory depth in words
- DATA_WORDS, 3072, data memory depth in words (byte range 0x0000-0x2FFF)
- GP_INIT, 32'h0000_1800, value written to register 28
- SP_INIT, 32'h0000_2FFC, value written to register 29

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- in_data  in  32  stream word (header or payload)
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts word this cycle
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  10  instruction memory word address
- dmem_we  out  1  data memory write strobe
- dmem_addr  out  12  data memory word address
- mem_wdata  out  32  write data, shared by both memories
- rf_we  out  1  register file write strobe
- rf_waddr  out  5  register file write address
- rf_wdata  out  32  register file write data
- syscall  in  1  CPU syscall indication
- cpu_reset  out  1  reset to CPU; high until load completes
- done  out  1  load complete, CPU running or halted
- halted  out  1  syscall observed after release (sticky)
- error  out  1  malformed stream (sticky)

Behaviour:
- Reset (async, any state):
  - State goes to HEADER.
  - Outputs reset to: in_ready=0, all we=0, addresses=0, wdata=0, cpu_reset=1, done=0, halted=0, error=0.
  - in_ready rises the first cycle after reset deasserts.
- Transfer: occurs on a clock edge with in_valid=1 and in_ready=1. in_ready is 1 only in HEADER and LOAD.
- Header word format:
  - [31:30] = seg: 00 text, 01 data, 11 end, 10 illegal.
  - [15:0] = N payload words. Bits [29:16] are ignored.
- HEADER state:
  - seg 00/01 with N=0: no writes, stay in HEADER.
  - seg 00/01 with 1 <= N <= segment depth: latch seg and N, clear word counter, go to LOAD.
  - N > depth (TEXT_WORDS or DATA_WORDS): go to ERROR.
  - seg 11: go to INIT_GP.
  - seg 10: go to ERROR.
- LOAD state:
  - Each accepted word k (0..N-1) is written to word address k of the selected memory.
  - Write strobe, address and mem_wdata are registered: asserted for exactly one cycle, the cycle after acceptance.
  - After word N-1 is accepted, return to HEADER. A following header may be accepted on the very next edge, with no bubble.
  - Each new header restarts its segment at word 0, overwriting earlier contents.
  - in_valid low stalls the load; no writes are issued.
- INIT_GP: one cycle, rf_we=1, rf_waddr=28, rf_wdata=GP_INIT. Then INIT_SP.
- INIT_SP: one cycle, rf_we=1, rf_waddr=29, rf_wdata=SP_INIT. Then RUN.
- RUN:
  - cpu_reset=0 and done=1 from the first RUN cycle. in_ready=0; stream input is ignored.
  - syscall=1 on an edge: halted=1, go to HALT.
  - syscall is ignored before RUN.
- HALT: terminal. cpu_reset stays 0 and done stays 1; only reset exits.
- ERROR: terminal. error=1, in_ready=0, no writes, cpu_reset stays 1; only reset exits.
- Simultaneous events:
  - At most one memory strobe and one rf strobe are active per cycle.
  - imem_we and dmem_we are never both 1.
- Reset mid-LOAD: any pending write strobe is dropped. Already-written memory contents are not cleared.

Test Plan:
- Text load: stream 0x0000_0003, 0x2008_0005, 0x2009_0007, 0x0000_000C, then 0xC000_0000 with in_valid held high -> imem_we pulses at addresses 0,1,2 with those words. Then rf writes r28=0x1800, r29=0x2FFC on consecutive cycles. cpu_reset falls and done=1 on the next cycle.
- Mixed segments with stalls: 0x0000_0001, 0x0000_000C, 0x4000_0002, 0xDEAD_BEEF, 0x1234_5678, 0xC000_0000, with in_valid toggling every other cycle -> imem[0]=0x0000000C, dmem[0]=0xDEADBEEF, dmem[1]=0x12345678. No writes occur on stall cycles.
- Illegal segment: header 0x8000_0001 -> error=1 the next cycle, in_ready=0, cpu_reset stays 1, no write strobes thereafter.
- Overflow: header 0x0000_0401 (N=1025 > TEXT_WORDS) -> error=1, no imem writes. Header 0x4000_0000 (N=0) -> stays in HEADER, in_ready=1.
- Halt: after a completed load, hold syscall=0 for 5 cycles, then 1 for one cycle -> halted=1 on that edge and stays 1 after syscall drops. done stays 1, cpu_reset stays 0.
- Reset mid-load: assert reset between payload words 1 and 2 of a 3-word text load -> all outputs return to reset values asynchronously. A fresh stream afterwards loads correctly from word 0.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: parses a header/payload word stream into instruction and data
// memory, seeds $gp/$sp, releases the CPU from reset and then watches for a halting syscall.
module prog_loader #(
  parameter int          TEXT_WORDS = 1024,
  parameter int          DATA_WORDS = 3072,
  parameter logic [31:0] GP_INIT    = 32'h0000_1800,
  parameter logic [31:0] SP_INIT    = 32'h0000_2FFC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic        dmem_we,
  output logic [11:0] dmem_addr,
  output logic [31:0] mem_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        syscall,
  output logic        cpu_reset,
  output logic        done,
  output logic        halted,
  output logic        error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_HEADER  = 3'd0,
    S_LOAD    = 3'd1,
    S_INIT_GP = 3'd2,
    S_INIT_SP = 3'd3,
    S_RUN     = 3'd4,
    S_HALT    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready is a register that is 1 only while the next state is HEADER or LOAD.
  state_t      r_state;
  state_t      w_next;
  logic        r_in_ready;
  logic        r_seg_data;
  logic [15:0] r_len;
  logic [15:0] r_count;
  logic        r_imem_we;
  logic        r_dmem_we;
  logic [9:0]  r_imem_addr;
  logic [11:0] r_dmem_addr;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic [1:0]  w_seg;
  logic [15:0] w_len;
  logic [16:0] w_depth;
  logic        w_start_load;
  logic        w_unused_bits;

  assign w_accept      = in_valid & r_in_ready;
  assign w_seg         = in_data[31:30];
  assign w_len         = in_data[15:0];
  assign w_depth       = w_seg[0] ? 17'(DATA_WORDS) : 17'(TEXT_WORDS);
  assign w_unused_bits = ^in_data[29:16];
  assign w_start_load  = (r_state == S_HEADER) && w_accept && !w_seg[1] &&
                         (w_len != 16'd0) && ({1'b0, w_len} <= w_depth);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HEADER: begin
        if (w_accept) begin
          case (w_seg)
            2'b00, 2'b01: begin
              if ({1'b0, w_len} > w_depth) w_next = S_ERROR;
              else if (w_len != 16'd0)     w_next = S_LOAD;
            end
            2'b11:   w_next = S_INIT_GP;
            default: w_next = S_ERROR;
          endcase
        end
      end
      S_LOAD: begin
        if (w_accept && (r_count == r_len - 16'd1)) w_next = S_HEADER;
      end
      S_INIT_GP: w_next = S_INIT_SP;
      S_INIT_SP: w_next = S_RUN;
      S_RUN:     if (syscall) w_next = S_HALT;
      default:   w_next = r_state;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_HEADER;
      r_in_ready  <= 1'b0;
      r_seg_data  <= 1'b0;
      r_len       <= '0;
      r_count     <= '0;
      r_imem_we   <= 1'b0;
      r_dmem_we   <= 1'b0;
      r_imem_addr <= '0;
      r_dmem_addr <= '0;
      r_wdata     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_HEADER) || (w_next == S_LOAD);
      r_imem_we  <= 1'b0;
      r_dmem_we  <= 1'b0;
      if (w_start_load) begin
        r_seg_data <= w_seg[0];
        r_len      <= w_len;
        r_count    <= '0;
      end
      // Payload strobes are registered so they land the cycle after acceptance.
      if ((r_state == S_LOAD) && w_accept) begin
        r_count   <= r_count + 16'd1;
        r_wdata   <= in_data;
        r_imem_we <= !r_seg_data;
        r_dmem_we <= r_seg_data;
        if (r_seg_data) r_dmem_addr <= r_count[11:0];
        else            r_imem_addr <= r_count[9:0];
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign imem_we   = r_imem_we;
  assign dmem_we   = r_dmem_we;
  assign imem_addr = r_imem_addr;
  assign dmem_addr = r_dmem_addr;
  assign mem_wdata = r_wdata;

  assign rf_we     = (r_state == S_INIT_GP) || (r_state == S_INIT_SP);
  assign rf_waddr  = (r_state == S_INIT_GP) ? 5'd28 : (r_state == S_INIT_SP) ? 5'd29 : 5'd0;
  assign rf_wdata  = (r_state == S_INIT_GP) ? GP_INIT : (r_state == S_INIT_SP) ? SP_INIT : 32'd0;

  assign done      = (r_state == S_RUN) || (r_state == S_HALT);
  assign cpu_reset = !done;
  assign halted    = (r_state == S_HALT);
  assign error     = (r_state == S_ERROR);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: memory and register-file writes are checked
// against expected queues filled as stream words are accepted.
module tb_prog_loader;

  logic        clock;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic        dmem_we;
  logic [11:0] dmem_addr;
  logic [31:0] mem_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        syscall;
  logic        cpu_reset;
  logic        done;
  logic        halted;
  logic        error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [44:0] exp_q[$];
  logic [36:0] rf_q[$];

  prog_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .mem_wdata(mem_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .syscall(syscall), .cpu_reset(cpu_reset), .done(done), .halted(halted),
    .error(error), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // kind: 0 header, 1 text payload, 2 data payload, 3 end header (expects rf writes)
  task automatic send(input logic [31:0] w, input int kind, input int idx);
    int t = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      check("ready_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (kind == 1) exp_q.push_back({1'b0, 12'(idx), w});
    if (kind == 2) exp_q.push_back({1'b1, 12'(idx), w});
    if (kind == 3) begin
      rf_q.push_back({5'd28, 32'h0000_1800});
      rf_q.push_back({5'd29, 32'h0000_2FFC});
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    in_valid = 1'b0;
    while (!done && t < 20) begin
      @(negedge clock);
      t++;
    end
    check(tag, {63'd0, done}, 64'd1);
  endtask

  // Write monitor: every strobe must match the head of its expected queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (imem_we || dmem_we) begin
        check("dual_strobe", {63'd0, imem_we & dmem_we}, 64'd0);
        check("mem_q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0)
          check("mem_write", {19'd0, dmem_we, dmem_we ? dmem_addr : {2'b00, imem_addr}, mem_wdata},
                {19'd0, exp_q.pop_front()});
      end
      if (rf_we) begin
        check("rf_q_nonempty", {63'd0, rf_q.size() != 0}, 64'd1);
        if (rf_q.size() != 0)
          check("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, rf_q.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] words[4];
    reset = 1'b1; in_valid = 1'b0; in_data = '0; syscall = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_strobes", {61'd0, imem_we, dmem_we, rf_we}, 64'd0);
    check("rst_addr_wdata", {10'd0, imem_addr, dmem_addr, mem_wdata}, 64'd0);
    check("rst_flags", {60'd0, cpu_reset, done, halted, error}, 64'h8);
    @(negedge clock);
    reset = 1'b0;
    check("ready_low_after_release", {63'd0, in_ready}, 64'd0);
    @(negedge clock);
    check("ready_rises", {63'd0, in_ready}, 64'd1);

    // Text load, back-to-back words
    words = '{32'h2008_0005, 32'h2009_0007, 32'h0000_000C, 32'h0};
    send(32'h0000_0003, 0, 0);
    for (int i = 0; i < 3; i++) send(words[i], 1, i);
    send(32'hC000_0000, 3, 0);
    in_valid = 1'b0;
    check("init_gp", {26'd0, rf_we, rf_waddr, rf_wdata}, {26'd0, 1'b1, 5'd28, 32'h1800});
    check("init_gp_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    @(negedge clock);
    check("init_sp", {26'd0, rf_we, rf_waddr, rf_wdata}, {26'd0, 1'b1, 5'd29, 32'h2FFC});
    @(negedge clock);
    check("run_flags", {60'd0, cpu_reset, done, in_ready, rf_we}, 64'h4);

    // Halt after five quiet cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("no_halt_yet", {63'd0, halted}, 64'd0);
    end
    syscall = 1'b1;
    @(negedge clock);
    syscall = 1'b0;
    check("halted_set", {63'd0, halted}, 64'd1);
    @(negedge clock);
    check("halt_sticky", {61'd0, halted, done, cpu_reset}, 64'h6);

    // Mixed segments with stalls
    do_reset();
    send(32'h0000_0001, 0, 0);       in_valid = 1'b0; @(negedge clock);
    send(32'h0000_000C, 1, 0);       in_valid = 1'b0; @(negedge clock);
    send(32'h4000_0002, 0, 0);       in_valid = 1'b0; @(negedge clock);
    send(32'hDEAD_BEEF, 2, 0);       in_valid = 1'b0; @(negedge clock);
    send(32'h1234_5678, 2, 1);       in_valid = 1'b0; @(negedge clock);
    send(32'hC000_0000, 3, 0);
    wait_done("mixed_done");
    check("mixed_q_drained", {32'd0, 32'(exp_q.size() + rf_q.size())}, 64'd0);

    // Illegal segment, then stream words must be ignored
    do_reset();
    send(32'h8000_0001, 0, 0);
    check("illegal_flags", {61'd0, error, in_ready, cpu_reset}, 64'h5);
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("illegal_sticky", {62'd0, error, in_ready}, 64'h2);

    // Oversize text and data headers
    do_reset();
    send(32'h0000_0401, 0, 0);
    in_valid = 1'b0;
    check("text_overflow", {62'd0, error, in_ready}, 64'h2);
    do_reset();
    send(32'h4000_0C01, 0, 0);
    in_valid = 1'b0;
    check("data_overflow", {63'd0, error}, 64'd1);

    // Zero-length header, then a full-depth text segment
    do_reset();
    send(32'h4000_0000, 0, 0);
    in_valid = 1'b0;
    check("zero_len", {61'd0, in_ready, error, dbg_state == 3'd0}, 64'h5);
    send(32'h0000_0400, 0, 0);
    for (int i = 0; i < 1024; i++) send($urandom, 1, i);
    send(32'hC000_0000, 3, 0);
    wait_done("full_text_done");

    // Reset between payload words 1 and 2
    do_reset();
    send(32'h0000_0003, 0, 0);
    send(32'h1111_1111, 1, 0);
    send(32'h2222_2222, 1, 1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midload_strobes", {61'd0, imem_we, dmem_we, rf_we}, 64'd0);
    check("midload_addr_wdata", {10'd0, imem_addr, dmem_addr, mem_wdata}, 64'd0);
    check("midload_flags", {59'd0, in_ready, cpu_reset, done, halted, error}, 64'h8);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send(32'h0000_0002, 0, 0);
    send(32'hAAAA_0001, 1, 0);
    send(32'hAAAA_0002, 1, 1);
    send(32'hC000_0000, 3, 0);
    wait_done("reload_done");

    repeat (3) @(negedge clock);
    check("final_q_drained", {32'd0, 32'(exp_q.size() + rf_q.size())}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
